sme_input_buffer: RTL and testbench

//  Upstream stage of the string-matching engine. Captures the serial chardata stream
//  (string, then pattern) into register files. Strips '^'/'$' anchors into flags and

---
 rtl/sme_pkg.sv | 20 ++
 rtl/sme_pat_parser.sv | 97 +++++++++
 rtl/sme_input_buffer.sv | 148 ++++++++++++++
 tb/tb_sme_input_buffer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sme_pkg.sv
// rtl/sme_pkg.sv - shared constants and state encoding for the string-matching engine input stage
package sme_pkg;

    localparam logic [7:0] CH_CARET  = 8'h5E;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_DOT    = 8'h2E;
    localparam logic [7:0] CH_SPACE  = 8'h20;

    localparam int STR_MAX_DEF = 32;
    localparam int PAT_MAX_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD_STR = 2'd1,
        ST_LOAD_PAT = 2'd2,
        ST_READY    = 2'd3
    } sme_state_t;

endpackage

// File: rtl/sme_pat_parser.sv
// rtl/sme_pat_parser.sv - on-the-fly pattern parser: anchor strip, star detect, body buffer
module sme_pat_parser
    import sme_pkg::*;
#(
    parameter int PAT_MAX = PAT_MAX_DEF,
    parameter int PLW     = $clog2(PAT_MAX) + 1,
    parameter int SIW     = $clog2(PAT_MAX)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic                 i_push,
    input  logic                 i_final,
    input  logic [7:0]           i_char,
    output logic [8*PAT_MAX-1:0] o_pat_flat,
    output logic [PLW-1:0]       o_pat_len,
    output logic                 o_anchor_head,
    output logic                 o_anchor_tail,
    output logic                 o_has_star,
    output logic [SIW-1:0]       o_star_idx,
    output logic                 o_ovf
);

    localparam logic [PLW-1:0] RAW_FULL = PLW'(PAT_MAX);

    logic [7:0]     r_pat_mem [PAT_MAX];
    logic [PLW-1:0] r_pat_len;
    logic [PLW-1:0] r_raw_cnt;
    logic           r_anchor_head;
    logic           r_anchor_tail;
    logic           r_has_star;
    logic [SIW-1:0] r_star_idx;

    logic           w_raw_full;
    logic           w_is_caret;
    logic           w_store;
    logic [PLW-1:0] w_cur_len;
    logic           w_cur_star;
    logic [PLW-1:0] w_len_m1;
    logic           w_strip_tail;

    // i_start begins a fresh pattern, so the running fields are viewed as cleared for that char
    assign w_raw_full   = !i_start && (r_raw_cnt == RAW_FULL);
    assign w_is_caret   = i_start && (i_char == CH_CARET);
    assign w_store      = (i_start || i_push) && !w_raw_full && !w_is_caret;
    assign w_cur_len    = i_start ? '0 : r_pat_len;
    assign w_cur_star   = i_start ? 1'b0 : r_has_star;
    assign w_len_m1     = r_pat_len - 1'b1;
    assign w_strip_tail = i_final && (r_pat_len != '0) && (r_pat_mem[w_len_m1[SIW-1:0]] == CH_DOLLAR);
    assign o_ovf        = i_push && w_raw_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < PAT_MAX; k++) r_pat_mem[k] <= '0;
            r_pat_len     <= '0;
            r_raw_cnt     <= '0;
            r_anchor_head <= 1'b0;
            r_anchor_tail <= 1'b0;
            r_has_star    <= 1'b0;
            r_star_idx    <= '0;
        end else begin
            if (i_start) begin
                r_raw_cnt     <= PLW'(1);
                r_anchor_head <= w_is_caret;
                r_anchor_tail <= 1'b0;
                r_has_star    <= 1'b0;
                r_star_idx    <= '0;
                r_pat_len     <= '0;
            end else if (i_push && !w_raw_full) begin
                r_raw_cnt <= r_raw_cnt + 1'b1;
            end
            if (w_store) begin
                r_pat_mem[w_cur_len[SIW-1:0]] <= i_char;
                r_pat_len <= w_cur_len + 1'b1;
                if (i_char == CH_STAR && !w_cur_star) begin
                    r_has_star <= 1'b1;
                    r_star_idx <= w_cur_len[SIW-1:0];
                end
            end
            if (w_strip_tail) begin
                r_pat_len     <= w_len_m1;
                r_anchor_tail <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < PAT_MAX; k++) begin : g_pat_flat
        assign o_pat_flat[8*k +: 8] = r_pat_mem[k];
    end

    assign o_pat_len     = r_pat_len;
    assign o_anchor_head = r_anchor_head;
    assign o_anchor_tail = r_anchor_tail;
    assign o_has_star    = r_has_star;
    assign o_star_idx    = r_star_idx;

endmodule

// File: rtl/sme_input_buffer.sv
// rtl/sme_input_buffer.sv - captures string and pattern streams and presents one parsed job to the matcher
module sme_input_buffer
    import sme_pkg::*;
#(
    parameter int STR_MAX = STR_MAX_DEF,
    parameter int PAT_MAX = PAT_MAX_DEF,
    parameter int SLW     = $clog2(STR_MAX) + 1,
    parameter int PLW     = $clog2(PAT_MAX) + 1,
    parameter int SIW     = $clog2(PAT_MAX)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           chardata,
    input  logic                 isstring,
    input  logic                 ispattern,
    output logic                 job_valid,
    input  logic                 job_ready,
    output logic [8*STR_MAX-1:0] str_flat,
    output logic [SLW-1:0]       str_len,
    output logic [8*PAT_MAX-1:0] pat_flat,
    output logic [PLW-1:0]       pat_len,
    output logic                 anchor_head,
    output logic                 anchor_tail,
    output logic                 has_star,
    output logic [SIW-1:0]       star_idx,
    output logic                 err_flag
);

    localparam logic [SLW-1:0] STR_FULL = SLW'(STR_MAX);

    sme_state_t r_state;
    sme_state_t w_next;

    logic [7:0]     r_str_mem [STR_MAX];
    logic [SLW-1:0] r_str_len;
    logic           r_err_flag;

    logic w_str_first;
    logic w_str_app;
    logic w_pat_start;
    logic w_pat_push;
    logic w_final;
    logic w_proto_err;
    logic w_str_ovf;
    logic w_pat_ovf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // isstring takes priority whenever both strobes are high
    always_comb begin
        w_next      = r_state;
        w_str_first = 1'b0;
        w_str_app   = 1'b0;
        w_pat_start = 1'b0;
        w_pat_push  = 1'b0;
        w_final     = 1'b0;
        w_proto_err = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (isstring) begin
                    w_str_first = 1'b1;
                    w_proto_err = ispattern;
                    w_next      = ST_LOAD_STR;
                end else if (ispattern) begin
                    w_pat_start = 1'b1;
                    w_next      = ST_LOAD_PAT;
                end
            end
            ST_LOAD_STR: begin
                if (isstring) begin
                    w_str_app   = 1'b1;
                    w_proto_err = ispattern;
                end else if (ispattern) begin
                    w_pat_start = 1'b1;
                    w_next      = ST_LOAD_PAT;
                end
            end
            ST_LOAD_PAT: begin
                if (isstring) begin
                    w_final     = 1'b1;
                    w_proto_err = 1'b1;
                    w_next      = ST_READY;
                end else if (ispattern) begin
                    w_pat_push = 1'b1;
                end else begin
                    w_final = 1'b1;
                    w_next  = ST_READY;
                end
            end
            ST_READY: begin
                w_proto_err = isstring || ispattern;
                if (job_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_str_ovf = w_str_app && (r_str_len == STR_FULL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < STR_MAX; k++) r_str_mem[k] <= '0;
            r_str_len  <= '0;
            r_err_flag <= 1'b0;
        end else begin
            if (w_str_first) begin
                r_str_mem[0] <= chardata;
                r_str_len    <= SLW'(1);
            end else if (w_str_app && !w_str_ovf) begin
                r_str_mem[r_str_len[SLW-2:0]] <= chardata;
                r_str_len <= r_str_len + 1'b1;
            end
            if (w_proto_err || w_str_ovf || w_pat_ovf) r_err_flag <= 1'b1;
        end
    end

    sme_pat_parser #(
        .PAT_MAX (PAT_MAX),
        .PLW     (PLW),
        .SIW     (SIW)
    ) u_pat_parser (
        .clk           (clk),
        .rst           (reset),
        .i_start       (w_pat_start),
        .i_push        (w_pat_push),
        .i_final       (w_final),
        .i_char        (chardata),
        .o_pat_flat    (pat_flat),
        .o_pat_len     (pat_len),
        .o_anchor_head (anchor_head),
        .o_anchor_tail (anchor_tail),
        .o_has_star    (has_star),
        .o_star_idx    (star_idx),
        .o_ovf         (w_pat_ovf)
    );

    for (genvar k = 0; k < STR_MAX; k++) begin : g_str_flat
        assign str_flat[8*k +: 8] = r_str_mem[k];
    end

    assign job_valid = (r_state == ST_READY);
    assign str_len   = r_str_len;
    assign err_flag  = r_err_flag;

endmodule

// File: tb/tb_sme_input_buffer.sv
// tb/tb_sme_input_buffer.sv - scoreboard bench for sme_input_buffer
module tb_sme_input_buffer;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   chardata;
    logic         isstring;
    logic         ispattern;
    logic         job_valid;
    logic         job_ready;
    logic [255:0] str_flat;
    logic [5:0]   str_len;
    logic [63:0]  pat_flat;
    logic [3:0]   pat_len;
    logic         anchor_head;
    logic         anchor_tail;
    logic         has_star;
    logic [2:0]   star_idx;
    logic         err_flag;

    sme_input_buffer dut (
        .clk         (clk),
        .reset       (reset),
        .chardata    (chardata),
        .isstring    (isstring),
        .ispattern   (ispattern),
        .job_valid   (job_valid),
        .job_ready   (job_ready),
        .str_flat    (str_flat),
        .str_len     (str_len),
        .pat_flat    (pat_flat),
        .pat_len     (pat_len),
        .anchor_head (anchor_head),
        .anchor_tail (anchor_tail),
        .has_star    (has_star),
        .star_idx    (star_idx),
        .err_flag    (err_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] str;
        int           slen;
        logic [63:0]  pat;
        int           plen;
        bit           ah;
        bit           at;
        bit           hs;
        int           si;
        bit           err;
        int           rise;
    } job_t;

    job_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   last_c;
    bit   prev_v = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] byte_mask(input int n);
        logic [255:0] m = '0;
        for (int k = 0; k < n; k++) m[8*k +: 8] = 8'hFF;
        return m;
    endfunction

    function automatic job_t mk(input string s, input string p, input bit ah, input bit at,
                                input bit hs, input int si, input bit err, input int rise);
        job_t j;
        j.str = '0;
        j.pat = '0;
        for (int k = 0; k < s.len(); k++) j.str[8*k +: 8] = s[k];
        for (int k = 0; k < p.len(); k++) j.pat[8*k +: 8] = p[k];
        j.slen = s.len();
        j.plen = p.len();
        j.ah = ah; j.at = at; j.hs = hs; j.si = si; j.err = err; j.rise = rise;
        return j;
    endfunction

    // monitor: compare every cycle the job is presented, pop on handshake
    always @(negedge clk) begin
        if (reset) begin
            prev_v = 1'b0;
        end else begin
            if (job_valid) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_job actual=valid required=no_job");
                end else begin
                    if (!prev_v) chk("rise_cycle", cyc, q[0].rise);
                    chk("str_flat", str_flat & byte_mask(q[0].slen), q[0].str & byte_mask(q[0].slen));
                    chk("str_len", str_len, q[0].slen);
                    chk("pat_flat", {192'd0, pat_flat} & byte_mask(q[0].plen), {192'd0, q[0].pat} & byte_mask(q[0].plen));
                    chk("pat_len", pat_len, q[0].plen);
                    chk("anchor_head", anchor_head, q[0].ah);
                    chk("anchor_tail", anchor_tail, q[0].at);
                    chk("has_star", has_star, q[0].hs);
                    chk("star_idx", star_idx, q[0].si);
                    chk("err_flag", err_flag, q[0].err);
                end
            end
            prev_v = job_valid;
        end
    end

    always @(posedge clk) begin
        if (!reset && job_valid && job_ready && q.size() > 0) void'(q.pop_front());
    end

    task automatic drive(input bit s, input bit p, input logic [7:0] c);
        @(negedge clk);
        isstring = s; ispattern = p; chardata = c;
    endtask

    task automatic idle_cyc();
        drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_str(input string s);
        for (int k = 0; k < s.len(); k++) drive(1'b1, 1'b0, s[k]);
    endtask

    task automatic send_pat(input string p);
        for (int k = 0; k < p.len(); k++) drive(1'b0, 1'b1, p[k]);
        last_c = cyc;
    endtask

    task automatic accept(input int hold);
        for (int i = 0; i < 20 && !job_valid; i++) @(negedge clk);
        if (!job_valid) begin
            total++; bad++;
            $display("FAIL job_timeout actual=0 required=1");
        end
        repeat (hold) @(negedge clk);
        job_ready = 1'b1;
        @(negedge clk);
        job_ready = 1'b0;
        chk("valid_drop", job_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        string s32;
        reset = 1'b1; chardata = '0; isstring = 0; ispattern = 0; job_ready = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", job_valid, 0);
        chk("rst_str_len", str_len, 0);
        chk("rst_pat_len", pat_len, 0);
        chk("rst_flags", {anchor_head, anchor_tail, has_star, star_idx, err_flag}, 0);
        chk("rst_str_flat", str_flat, 0);

        // basic job held 10 cycles, then accepted
        send_str("hello");
        send_pat("ell");
        q.push_back(mk("hello", "ell", 0, 0, 0, 0, 0, last_c + 2));
        idle_cyc();
        accept(10);

        // pattern-only jobs keep the previous string
        send_pat("^h.*o$");
        q.push_back(mk("hello", "h.*o", 1, 1, 1, 2, 0, last_c + 2));
        idle_cyc();
        accept(0);

        send_pat("lo");
        q.push_back(mk("hello", "lo", 0, 0, 0, 0, 0, last_c + 2));
        idle_cyc();
        accept(2);

        send_str("xy");
        send_pat("*$*");
        q.push_back(mk("xy", "*$*", 0, 0, 1, 0, 0, last_c + 2));
        idle_cyc();
        accept(1);

        // string overflow, then simultaneous strobes
        s32 = "";
        for (int k = 0; k < 32; k++) s32 = {s32, $sformatf("%c", 8'h41 + (k % 26))};
        send_str(s32);
        drive(1'b1, 1'b0, 8'h47);
        drive(1'b0, 1'b0, 8'h00);
        chk("ovf_str_len", str_len, 32);
        chk("ovf_err", err_flag, 1);
        drive(1'b1, 1'b1, 8'h5A);
        drive(1'b0, 1'b0, 8'h00);
        chk("both_err", err_flag, 1);
        chk("both_str_len", str_len, 32);
        send_pat("q");
        q.push_back(mk(s32, "q", 0, 0, 0, 0, 1, last_c + 2));
        idle_cyc();
        accept(0);

        // reset during LOAD_PAT discards the partial job
        send_str("abc");
        send_pat("xy");
        @(negedge clk);
        reset = 1'b1;
        isstring = 0; ispattern = 0;
        @(negedge clk);
        chk("midrst_valid", job_valid, 0);
        chk("midrst_err", err_flag, 0);
        chk("midrst_str_len", str_len, 0);
        reset = 1'b0;
        @(negedge clk);

        send_str("cat");
        send_pat("^a");
        q.push_back(mk("cat", "a", 1, 0, 0, 0, 0, last_c + 2));
        idle_cyc();
        accept(0);

        // raw pattern overflow: only PAT_MAX raw chars kept, caret included
        send_pat("^abcdefghij");
        q.push_back(mk("cat", "abcdefg", 1, 0, 0, 0, 1, last_c + 2));
        idle_cyc();
        accept(0);

        // isstring during LOAD_PAT finalizes the pattern and drops the char
        send_pat("ab");
        q.push_back(mk("cat", "ab", 0, 0, 0, 0, 1, last_c + 2));
        drive(1'b1, 1'b0, 8'h51);
        idle_cyc();
        accept(0);

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
